// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one pipelined multiply-add among NUM_REQ requesters; MULT_ARB_STALL_EN adds result_ready back-pressure
module mult_share_arbiter #(
  parameter int    NUM_REQ        = 4,
  parameter int    WIDTHA         = 8,
  parameter int    WIDTHB         = 8,
  parameter int    WIDTHS         = 16,
  parameter int    WIDTHP         = 16,
  parameter int    PIPELINE       = 2,
  parameter string REPRESENTATION = "UNSIGNED"
) (
  input  logic                         clock,
  input  logic                         aclr,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*WIDTHA-1:0]    dataa_bus,
  input  logic [NUM_REQ*WIDTHB-1:0]    datab_bus,
  input  logic [NUM_REQ*WIDTHS-1:0]    sum_bus,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [WIDTHP-1:0]            result,
  output logic                         result_valid,
  output logic [$clog2(NUM_REQ)-1:0]   result_id,
  output logic                         busy
`ifdef MULT_ARB_STALL_EN
  ,
  input  logic                         result_ready
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int FW = (WIDTHA + WIDTHB > WIDTHS) ? WIDTHA + WIDTHB : WIDTHS;
  localparam bit SGN = (REPRESENTATION == "SIGNED");
  logic [IW-1:0]     ptr, gidx;
  logic              found, take, stall;
  int                j;
  logic [WIDTHA-1:0] a_r;
  logic [WIDTHB-1:0] b_r;
  logic [WIDTHS-1:0] s_r;
  logic [FW-1:0]     ae, be, se, full;
  logic [WIDTHP-1:0] res;
  logic [WIDTHP-1:0] pipe [PIPELINE];
  logic [PIPELINE:0] v;
  logic [IW-1:0]     ids [PIPELINE+1];
`ifdef MULT_ARB_STALL_EN
  assign stall = result_valid & ~result_ready;
`else
  assign stall = 1'b0;
`endif
  // first requester at or after ptr, wrapping; suppressed during reset and stall
  always_comb begin
    found = 1'b0;
    gidx = '0;
    j = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        gidx = IW'(j);
      end
    end
    take = found & ~stall & ~aclr;
    gnt = take ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gidx) : '0;
  end
  // grant pointer, operand capture and the valid/id tags that travel with each op
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      ptr <= '0;
      a_r <= '0;
      b_r <= '0;
      s_r <= '0;
      v <= '0;
      for (int i = 0; i <= PIPELINE; i++) ids[i] <= '0;
    end else if (!stall) begin
      v <= {v[PIPELINE-1:0], take};
      ids[0] <= take ? gidx : '0;
      for (int i = 1; i <= PIPELINE; i++) ids[i] <= ids[i-1];
      if (take) begin
        a_r <= dataa_bus[gidx*WIDTHA +: WIDTHA];
        b_r <= datab_bus[gidx*WIDTHB +: WIDTHB];
        s_r <= sum_bus[gidx*WIDTHS +: WIDTHS];
        ptr <= (gidx == IW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
      end
    end
  end
  // operands extended to the full product width, sign-filled only in signed mode
  assign ae = {{(FW-WIDTHA){SGN & a_r[WIDTHA-1]}}, a_r};
  assign be = {{(FW-WIDTHB){SGN & b_r[WIDTHB-1]}}, b_r};
  generate
    if (WIDTHS < FW) begin : g_sx
      assign se = {{(FW-WIDTHS){SGN & s_r[WIDTHS-1]}}, s_r};
    end else begin : g_sn
      assign se = s_r;
    end
    if (WIDTHP <= FW) begin : g_msb
      assign res = WIDTHP'(full >> (FW - WIDTHP));
    end else begin : g_ext
      assign res = {{(WIDTHP-FW){SGN & full[FW-1]}}, full};
    end
  endgenerate
  assign full = ae * be + se;
  // multiplier output pipeline, frozen by the clock enable while stalled
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < PIPELINE; i++) pipe[i] <= '0;
    end else if (!stall) begin
      pipe[0] <= res;
      for (int i = 1; i < PIPELINE; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign result       = pipe[PIPELINE-1];
  assign result_valid = v[PIPELINE];
  assign result_id    = ids[PIPELINE];
  assign busy         = |v;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed checks of grant order, tagged results, signed math, reset and stall
module tb_mult_share_arbiter;
  logic        clock, aclr;
  logic [3:0]  req, s_req;
  logic [31:0] da, db, s_da, s_db;
  logic [63:0] sb, s_sb;
  logic [3:0]  gnt, s_gnt;
  logic [15:0] result, s_result;
  logic        result_valid, s_valid, busy, s_busy;
  logic [1:0]  result_id, s_id;
  logic        rdy;
  int          total, bad;
  logic [3:0]  exp_gnt [8];
  logic [1:0]  exp_id [8];
  logic [15:0] exp_res [4];

  mult_share_arbiter u_dut (
    .clock(clock), .aclr(aclr), .req(req), .dataa_bus(da), .datab_bus(db), .sum_bus(sb),
    .gnt(gnt), .result(result), .result_valid(result_valid), .result_id(result_id), .busy(busy)
`ifdef MULT_ARB_STALL_EN
    , .result_ready(rdy)
`endif
  );

  mult_share_arbiter #(.REPRESENTATION("SIGNED")) u_s (
    .clock(clock), .aclr(aclr), .req(s_req), .dataa_bus(s_da), .datab_bus(s_db), .sum_bus(s_sb),
    .gnt(s_gnt), .result(s_result), .result_valid(s_valid), .result_id(s_id), .busy(s_busy)
`ifdef MULT_ARB_STALL_EN
    , .result_ready(rdy)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    aclr = 1'b0; rdy = 1'b1;
    req = 4'b1111; s_req = 4'b0;
    da = '0; db = '0; sb = '0; s_da = '0; s_db = '0; s_sb = '0;
    #2 aclr = 1'b1;
    #1;
    check("rst_gnt", gnt, 4'b0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_result", result, 16'h0);
    check("rst_id", result_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    tick();
    req = 4'b0;
    aclr = 1'b0;
    // single op on requester 0: 3*5+7 = 22
    da[7:0] = 8'd3; db[7:0] = 8'd5; sb[15:0] = 16'd7;
    req = 4'b0001;
    #1 check("t1_gnt", gnt, 4'b0001);
    tick();
    req = 4'b0;
    #1;
    check("t1_gnt_drop", gnt, 4'b0);
    check("t1_busy", busy, 1'b1);
    check("t1_v0", result_valid, 1'b0);
    tick();
    check("t1_v1", result_valid, 1'b0);
    tick();
    check("t1_valid", result_valid, 1'b1);
    check("t1_result", result, 16'd22);
    check("t1_id", result_id, 2'd0);
    tick();
    check("t1_pulse_end", result_valid, 1'b0);
    check("t1_hold", result, 16'd22);
    check("t1_idle", busy, 1'b0);
    // all four requesting; ptr is 1 after the previous grant
    for (int i = 0; i < 4; i++) begin
      da[i*8 +: 8] = 8'(i + 1);
      db[i*8 +: 8] = 8'd2;
      sb[i*16 +: 16] = 16'(i * 10);
    end
    exp_res[0] = 16'd2; exp_res[1] = 16'd14; exp_res[2] = 16'd26; exp_res[3] = 16'd38;
    exp_gnt[0] = 4'b0010; exp_gnt[1] = 4'b0100; exp_gnt[2] = 4'b1000; exp_gnt[3] = 4'b0001;
    exp_gnt[4] = 4'b0010; exp_gnt[5] = 4'b0100; exp_gnt[6] = 4'b1000; exp_gnt[7] = 4'b0001;
    exp_id[0] = 2'd1; exp_id[1] = 2'd2; exp_id[2] = 2'd3; exp_id[3] = 2'd0;
    exp_id[4] = 2'd1; exp_id[5] = 2'd2; exp_id[6] = 2'd3; exp_id[7] = 2'd0;
    for (int c = 0; c < 11; c++) begin
      req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) check($sformatf("t2_gnt%0d", c), gnt, exp_gnt[c]);
      if (c >= 3) begin
        check($sformatf("t2_valid%0d", c), result_valid, 1'b1);
        check($sformatf("t2_id%0d", c), result_id, exp_id[c-3]);
        check($sformatf("t2_res%0d", c), result, exp_res[exp_id[c-3]]);
      end
      tick();
    end
    check("t2_done", result_valid, 1'b0);
    // move ptr to 2, then req 0011 must wrap to requester 0
    req = 4'b0010;
    #1 check("t3_pre", gnt, 4'b0010);
    tick();
    req = 4'b0011;
    #1 check("t3_wrap", gnt, 4'b0001);
    tick();
    check("t3_next", gnt, 4'b0010);
    tick();
    req = 4'b0;
    #1;
    check("t3_r1_id", result_id, 2'd1);
    check("t3_r1", result, 16'd14);
    tick();
    check("t3_r2_id", result_id, 2'd0);
    check("t3_r2", result, 16'd2);
    tick();
    check("t3_r3_id", result_id, 2'd1);
    check("t3_r3_v", result_valid, 1'b1);
    tick();
    // signed instance: -2*3+1 = -5 on id 2, -3*-4-1 = 11 on id 3
    s_da[23:16] = 8'hFE; s_db[23:16] = 8'h03; s_sb[47:32] = 16'h0001;
    s_da[31:24] = 8'hFD; s_db[31:24] = 8'hFC; s_sb[63:48] = 16'hFFFF;
    s_req = 4'b1100;
    #1 check("t4_gnt2", s_gnt, 4'b0100);
    tick();
    check("t4_gnt3", s_gnt, 4'b1000);
    tick();
    s_req = 4'b0;
    tick();
    check("t4_valid", s_valid, 1'b1);
    check("t4_res", s_result, 16'hFFFB);
    check("t4_id", s_id, 2'd2);
    tick();
    check("t4_res2", s_result, 16'h000B);
    check("t4_id2", s_id, 2'd3);
    tick();
    check("t4_end", s_valid, 1'b0);
    // reset with ops in flight
    req = 4'b1111;
    tick();
    tick();
    check("t5_busy_pre", busy, 1'b1);
    aclr = 1'b1;
    #1;
    check("t5_busy", busy, 1'b0);
    check("t5_valid", result_valid, 1'b0);
    check("t5_result", result, 16'h0);
    check("t5_gnt", gnt, 4'b0);
    tick();
    aclr = 1'b0;
    #1 check("t5_ptr0", gnt, 4'b0001);
    req = 4'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t5_quiet%0d", k), result_valid, 1'b0);
    end
`ifdef MULT_ARB_STALL_EN
    rdy = 1'b0;
    req = 4'b0011;
    #1 check("t6_g0", gnt, 4'b0001);
    tick();
    check("t6_g1", gnt, 4'b0010);
    tick();
    check("t6_g2", gnt, 4'b0001);
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t6_sv%0d", k), result_valid, 1'b1);
      check($sformatf("t6_sr%0d", k), result, 16'd2);
      check($sformatf("t6_si%0d", k), result_id, 2'd0);
      check($sformatf("t6_sg%0d", k), gnt, 4'b0);
      if (k < 2) tick();
    end
    rdy = 1'b1;
    #1 check("t6_resume", gnt, 4'b0010);
    tick();
    check("t6_a_id", result_id, 2'd1);
    check("t6_a_res", result, 16'd14);
    check("t6_a_gnt", gnt, 4'b0001);
    req = 4'b0;
    tick();
    check("t6_b_id", result_id, 2'd0);
    check("t6_b_res", result, 16'd2);
    tick();
    check("t6_c_id", result_id, 2'd1);
    check("t6_c_v", result_valid, 1'b1);
    tick();
    check("t6_end", result_valid, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
